// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron trainer: FSM state encoding,
// accumulator width helper and a width-parameterised saturating adder.
package perceptron_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, EVAL, UPDATE, DONE} state_t;

    function automatic int acc_w(input int w_w, input int x_w, input int n_in);
        return w_w + x_w + $clog2(n_in) + 2;
    endfunction

    // Adds at full precision, then clamps to the signed range of a w-bit word.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        longint s;
        longint hi;
        longint lo;
        s  = longint'(a) + longint'(b);
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return 32'(s);
    endfunction

endpackage

// File: rtl/perceptron_dot.sv
// Combinational dot product of signed weights with unsigned features, plus bias.
module perceptron_dot #(
    parameter int N_IN  = 2,
    parameter int X_W   = 3,
    parameter int W_W   = 8,
    parameter int ACC_W = 16
) (
    input  logic [N_IN*X_W-1:0]     x,
    input  logic [N_IN*W_W-1:0]     w,
    input  logic [W_W-1:0]          bias,
    output logic signed [ACC_W-1:0] sum
);

    logic [N_IN-1:0][ACC_W-1:0] prod;

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        logic signed [ACC_W-1:0] we;
        logic signed [ACC_W-1:0] xe;
        assign we      = ACC_W'($signed(w[i*W_W +: W_W]));
        assign xe      = ACC_W'({1'b0, x[i*X_W +: X_W]});
        assign prod[i] = we * xe;
    end

    always_comb begin
        logic signed [ACC_W-1:0] acc;
        acc = ACC_W'($signed(bias));
        for (int i = 0; i < N_IN; i++)
            acc = acc + $signed(prod[i]);
        sum = acc;
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: classifies streamed samples and applies the perceptron
// rule until an error-free epoch or MAX_EPOCH. Bias register: PERCEPTRON_BIAS_EN.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int X_W       = 3,
    parameter int W_W       = 8,
    parameter int W_INIT    = 1,
    parameter int LR_SHIFT  = 0,
    parameter int MAX_EPOCH = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [N_IN*X_W-1:0]              s_x,
    input  logic                             s_t,
    input  logic                             s_last,
    output logic [N_IN*W_W-1:0]              w_out,
    output logic [W_W-1:0]                   bias_out,
    output logic                             y,
    output logic                             y_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             converged,
    output logic [$clog2(MAX_EPOCH+1)-1:0]   epoch_cnt,
    output logic [$clog2(MAX_EPOCH)+8-1:0]   err_cnt
);

    localparam int              ACC_W      = acc_w(W_W, X_W, N_IN);
    localparam int              EC_W       = $clog2(MAX_EPOCH+1);
    localparam logic [W_W-1:0]  W_RST      = W_W'(W_INIT);
    localparam logic [EC_W-1:0] EPOCH_LAST = EC_W'(MAX_EPOCH-1);

    state_t                     state, state_nxt;
    logic [N_IN-1:0][W_W-1:0]   w, w_upd;
    logic [N_IN-1:0][X_W-1:0]   xr;
    logic                       tr, lastr;
    logic [W_W-1:0]             bias;
    logic signed [ACC_W-1:0]    sum;
    logic                       err, epoch_clean, epoch_final, restart;

    assign err         = (y != tr);
    assign epoch_clean = (err_cnt == '0) && !err;
    assign epoch_final = (epoch_cnt == EPOCH_LAST);
    assign restart     = ((state == IDLE) || (state == DONE)) && start;

    assign s_ready  = (state == WAIT);
    assign busy     = (state == WAIT) || (state == EVAL) || (state == UPDATE);
    assign y_valid  = (state == UPDATE);
    assign done     = (state == DONE);
    assign w_out    = w;
    assign bias_out = bias;

    perceptron_dot #(
        .N_IN (N_IN),
        .X_W  (X_W),
        .W_W  (W_W),
        .ACC_W(ACC_W)
    ) u_dot (
        .x   (xr),
        .w   (w),
        .bias(bias),
        .sum (sum)
    );

    // Step is x_i<<LR_SHIFT, added for t=1 and subtracted for t=0.
    always_comb begin
        w_upd = w;
        for (int i = 0; i < N_IN; i++)
            w_upd[i] = W_W'(sat_add(32'($signed(w[i])),
                                    tr ? $signed(32'(xr[i]) << LR_SHIFT)
                                       : -$signed(32'(xr[i]) << LR_SHIFT),
                                    W_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = WAIT;
            WAIT:       if (s_valid) state_nxt = EVAL;
            EVAL:       state_nxt = UPDATE;
            UPDATE: begin
                if (!lastr)
                    state_nxt = WAIT;
                else if (epoch_clean || epoch_final)
                    state_nxt = DONE;
                else
                    state_nxt = WAIT;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w         <= {N_IN{W_RST}};
            xr        <= '0;
            tr        <= 1'b0;
            lastr     <= 1'b0;
            y         <= 1'b0;
            converged <= 1'b0;
            epoch_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        w         <= {N_IN{W_RST}};
                        converged <= 1'b0;
                        epoch_cnt <= '0;
                        err_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (s_valid) begin
                        xr    <= s_x;
                        tr    <= s_t;
                        lastr <= s_last;
                    end
                end
                EVAL: y <= (sum > 0);
                UPDATE: begin
                    if (err) begin
                        w <= w_upd;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + 1'b1;
                    end
                    // Final epoch keeps its error count visible in DONE.
                    if (lastr) begin
                        epoch_cnt <= epoch_cnt + 1'b1;
                        if (epoch_clean)
                            converged <= 1'b1;
                        else if (!epoch_final)
                            err_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PERCEPTRON_BIAS_EN
    logic [W_W-1:0] bias_upd;
    assign bias_upd = W_W'(sat_add(32'($signed(bias)),
                                   tr ? (32'sd1 <<< LR_SHIFT) : -(32'sd1 <<< LR_SHIFT),
                                   W_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bias <= '0;
        else if (restart)
            bias <= '0;
        else if ((state == UPDATE) && err)
            bias <= bias_upd;
    end
`else
    assign bias = '0;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer against an integer reference model.
module tb_perceptron_trainer;

    localparam int N_IN = 2, X_W = 3, W_W = 8, W_INIT = 1, LR = 0, MAX_EPOCH = 64;
    localparam int EC_W = $clog2(MAX_EPOCH+1);
    localparam int ER_W = $clog2(MAX_EPOCH)+8;
`ifdef PERCEPTRON_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start, s_valid, s_ready, s_t, s_last;
    logic [N_IN*X_W-1:0] s_x;
    logic [N_IN*W_W-1:0] w_out;
    logic [W_W-1:0] bias_out;
    logic y, y_valid, busy, done, converged;
    logic [EC_W-1:0] epoch_cnt;
    logic [ER_W-1:0] err_cnt;

    logic start5, s5_valid, s5_ready, s5_t, s5_last;
    logic [N_IN*X_W-1:0] s5_x;
    logic [N_IN*W_W-1:0] w5_out;
    logic [W_W-1:0] bias5_out;
    logic y5, y5_valid, busy5, done5, conv5;
    logic [EC_W-1:0] epoch5;
    logic [ER_W-1:0] err5;

    always #5 clk = ~clk;

    perceptron_trainer #(.N_IN(N_IN), .X_W(X_W), .W_W(W_W), .W_INIT(W_INIT),
                         .LR_SHIFT(LR), .MAX_EPOCH(MAX_EPOCH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_t(s_t), .s_last(s_last), .w_out(w_out), .bias_out(bias_out),
        .y(y), .y_valid(y_valid), .busy(busy), .done(done), .converged(converged),
        .epoch_cnt(epoch_cnt), .err_cnt(err_cnt));

    perceptron_trainer #(.N_IN(N_IN), .X_W(X_W), .W_W(W_W), .W_INIT(W_INIT),
                         .LR_SHIFT(5), .MAX_EPOCH(MAX_EPOCH)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .s_valid(s5_valid), .s_ready(s5_ready),
        .s_x(s5_x), .s_t(s5_t), .s_last(s5_last), .w_out(w5_out), .bias_out(bias5_out),
        .y(y5), .y_valid(y5_valid), .busy(busy5), .done(done5), .converged(conv5),
        .epoch_cnt(epoch5), .err_cnt(err5));

    int vectors = 0, miscompares = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int dw(input int i);
        return int'($signed(w_out[i*W_W +: W_W]));
    endfunction

    // Reference model: plain integer perceptron.
    int  mw[N_IN];
    int  mb, merr, mep;
    bit  mdone, mconv;

    function automatic int clampw(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void m_start();
        for (int i = 0; i < N_IN; i++) mw[i] = W_INIT;
        mb = 0; merr = 0; mep = 0; mdone = 0; mconv = 0;
    endfunction

    function automatic bit m_step(input int x0, input int x1, input bit t, input bit last);
        int xs[N_IN];
        int s;
        bit yy;
        xs[0] = x0; xs[1] = x1;
        s = mb;
        for (int i = 0; i < N_IN; i++) s += mw[i] * xs[i];
        yy = (s > 0);
        if (yy != t) begin
            for (int i = 0; i < N_IN; i++)
                mw[i] = clampw(mw[i] + (t ? (xs[i] << LR) : -(xs[i] << LR)));
            if (BIAS_EN) mb = clampw(mb + (t ? (1 << LR) : -(1 << LR)));
            merr++;
        end
        if (last) begin
            mep++;
            if (merr == 0) begin mdone = 1; mconv = 1; end
            else if (mep == MAX_EPOCH) mdone = 1;
            else merr = 0;
        end
        return yy;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Drive one sample through handshake/EVAL/UPDATE and check against the model.
    task automatic apply(input int x0, input int x1, input bit t, input bit last, output bit yd);
        bit ey;
        int n;
        ey = m_step(x0, x1, t, last);
        @(negedge clk);
        s_x = {X_W'(x1), X_W'(x0)}; s_t = t; s_last = last; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        if (!s_ready) begin
            chk("handshake_timeout", 0, 1);
            s_valid = 1'b0; yd = 1'b0;
            return;
        end
        @(negedge clk) s_valid = 1'b0;
        @(negedge clk);
        chk("y_valid", int'(y_valid), 1);
        chk("y", int'(y), int'(ey));
        yd = y;
        @(negedge clk);
        chk("w0", dw(0), mw[0]);
        chk("w1", dw(1), mw[1]);
        chk("bias", int'($signed(bias_out)), mb);
        chk("err_cnt", int'(err_cnt), merr);
        chk("epoch_cnt", int'(epoch_cnt), mep);
        chk("done", int'(done), int'(mdone));
        chk("converged", int'(converged), int'(mconv));
    endtask

    typedef struct { int x0; int x1; bit t; } smp_t;
    smp_t sep[10];
    bit   yep[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit yd;
        int n;
        sep = '{'{0,2,1}, '{0,1,1}, '{2,0,0}, '{2,2,0}, '{0,3,1},
                '{1,0,0}, '{2,1,0}, '{1,2,0}, '{1,4,1}, '{0,7,1}};
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_x = '0; s_t = 1'b0; s_last = 1'b0;
        start5 = 1'b0; s5_valid = 1'b0; s5_x = '0; s5_t = 1'b0; s5_last = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_w0", dw(0), 1);
        chk("rst_w1", dw(1), 1);
        chk("rst_bias", int'(bias_out), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_converged", int'(converged), 0);
        chk("rst_epoch", int'(epoch_cnt), 0);
        chk("rst_err", int'(err_cnt), 0);

        // Single misclassified sample, epoch ends with an error.
        pulse_start(); m_start();
        chk("start_busy", int'(busy), 1);
        apply(2, 0, 1'b0, 1'b1, yd);
        chk("a_y", int'(yd), 1);
        chk("a_back_in_wait", int'(s_ready), 1);

        // start while busy must not restart training.
        pulse_start();
        chk("busy_start_epoch", int'(epoch_cnt), 1);
        chk("busy_start_w0", dw(0), mw[0]);

        // Correct first sample converges immediately.
        do_reset();
        pulse_start(); m_start();
        apply(0, 2, 1'b1, 1'b1, yd);
        chk("b_done", int'(done), 1);
        chk("b_conv", int'(converged), 1);
        chk("b_epoch", int'(epoch_cnt), 1);
        chk("b_busy", int'(busy), 0);

        // Separable 10-sample set, repeated until done.
        pulse_start(); m_start();
        for (int ep = 0; ep < MAX_EPOCH && !mdone; ep++)
            for (int i = 0; i < 10; i++) begin
                apply(sep[i].x0, sep[i].x1, sep[i].t, i == 9, yd);
                yep[i] = yd;
            end
        if (mconv)
            for (int i = 0; i < 10; i++) chk("replay_y", int'(yep[i]), int'(sep[i].t));

        // Contradictory labels never converge.
        pulse_start(); m_start();
        for (int ep = 0; ep < MAX_EPOCH && !mdone; ep++) begin
            apply(1, 1, 1'b1, 1'b0, yd);
            apply(1, 1, 1'b0, 1'b1, yd);
        end
        chk("nc_done", int'(done), 1);
        chk("nc_conv", int'(converged), 0);
        chk("nc_epoch", int'(epoch_cnt), 64);

        // Random samples.
        pulse_start(); m_start();
        for (int k = 0; k < 60 && !mdone; k++)
            apply(int'($urandom_range(7)), int'($urandom_range(7)), 1'($urandom_range(1)),
                  $urandom_range(3) == 0, yd);

        // Asynchronous reset during EVAL.
        if (mdone) begin pulse_start(); m_start(); end
        @(negedge clk);
        s_x = {3'd3, 3'd5}; s_t = 1'b0; s_last = 1'b0; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        chk("r_ready", int'(s_ready), 1);
        @(negedge clk) s_valid = 1'b0;
        chk("r_in_eval", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("r_busy", int'(busy), 0);
        chk("r_s_ready", int'(s_ready), 0);
        chk("r_y_valid", int'(y_valid), 0);
        chk("r_w0", dw(0), 1);
        chk("r_w1", dw(1), 1);
        chk("r_bias", int'(bias_out), 0);
        chk("r_epoch", int'(epoch_cnt), 0);
        @(negedge clk) rst_n = 1'b1;

        // LR_SHIFT=5 instance: large step saturates weights.
        @(negedge clk) start5 = 1'b1;
        @(negedge clk) start5 = 1'b0;
        s5_x = {3'd7, 3'd7}; s5_t = 1'b0; s5_last = 1'b1; s5_valid = 1'b1;
        n = 0;
        while (!s5_ready && n < 20) begin @(negedge clk); n++; end
        chk("lr_ready", int'(s5_ready), 1);
        @(negedge clk) s5_valid = 1'b0;
        @(negedge clk);
        chk("lr_y", int'(y5), 1);
        @(negedge clk);
        chk("lr_w0", int'($signed(w5_out[7:0])), -128);
        chk("lr_w1", int'($signed(w5_out[15:8])), -128);
        chk("lr_bias", int'($signed(bias5_out)), BIAS_EN ? -32 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Clocked, parametrised perceptron trainer for linearly separable classification experiments. It holds N_IN signed weights and an optional bias, and accepts labelled samples over a valid/ready stream. It classifies each sample and applies the perceptron update rule on every misclassification. It repeats epochs until an epoch completes with zero errors or the epoch limit is reached, then exposes the trained weights for downstream inference blocks.

## Interface
Parameters:
- N_IN, 2: number of input features.
- X_W, 3: width of each feature; features are unsigned.
- W_W, 8: width of each weight and of the bias; two's complement.
- W_INIT, 1: signed reset/restart value of every weight. The bias restarts at 0.
- LR_SHIFT, 0: learning-rate shift. The update step is x_i<<LR_SHIFT for weights and 1<<LR_SHIFT for the bias.
- MAX_EPOCH, 64: epoch limit.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse; starts training.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid&&s_ready.
- s_x  in  N_IN*X_W  features; feature i is s_x[i*X_W +: X_W].
- s_t  in  1  label; 1 means class +1, 0 means class -1.
- s_last  in  1  marks the last sample of an epoch.
- w_out  out  N_IN*W_W  current weights, packed the same way as s_x.
- bias_out  out  W_W  current bias.
- y  out  1  prediction for the most recently evaluated sample.
- y_valid  out  1  one-cycle pulse when y updates.
- busy  out  1  high from start until training ends.
- done  out  1  training finished; held high until the next start.
- converged  out  1  the last epoch had zero errors; valid while done is high.
- epoch_cnt  out  $clog2(MAX_EPOCH+1)  number of completed epochs.
- err_cnt  out  $clog2(MAX_EPOCH)+8  errors in the current epoch; saturating.

## Operation
- FSM states: IDLE, WAIT, EVAL, UPDATE, DONE.
- IDLE/DONE, start=1 → WAIT. This reloads the weights to W_INIT, sets the bias to 0, clears epoch_cnt and err_cnt, and clears done and converged.
- start is ignored in WAIT, EVAL and UPDATE.
- WAIT: s_ready=1. On handshake, register s_x, s_t and s_last, then → EVAL.
- EVAL: compute sum = bias + Σ $signed(w_i)*$signed({1'b0,x_i}).
  - The accumulator is ACC_W = W_W+X_W+$clog2(N_IN)+2 bits wide and cannot overflow.
  - Register y = (sum > 0); zero counts as class -1.
  - → UPDATE.
- UPDATE: pulse y_valid.
  - Error when y != t. On an error, increment err_cnt (saturating).
  - If t=1, add the step to each weight and to the bias. If t=0, subtract it.
  - Every sum saturates to [-2^(W_W-1), 2^(W_W-1)-1].
  - If the registered last bit is clear → WAIT.
- Epoch end (UPDATE with last set): epoch_cnt+1.
  - If the epoch error total including this sample is 0 → DONE with converged=1.
  - Else if epoch_cnt+1 == MAX_EPOCH → DONE with converged=0.
  - Else clear err_cnt → WAIT.
- In DONE, err_cnt holds the final epoch's count.
- Samples presented outside WAIT are not accepted (s_ready=0).

## Timing
- Reset values:
  - State IDLE; weights W_INIT; bias 0.
  - s_ready, y, y_valid, busy, done and converged all 0.
  - epoch_cnt and err_cnt 0.
- Handshake at edge k. EVAL runs in cycle k+1. UPDATE runs in cycle k+2, where y and y_valid are visible and the weights are written at the end of the cycle. s_ready returns in cycle k+3, so maximum throughput is one sample per 3 cycles.
- w_out and bias_out are stable except on the UPDATE edge.
- busy is high in WAIT, EVAL and UPDATE.
- done rises on the edge leaving UPDATE.
- If rst_n is asserted mid-operation, everything returns to reset values immediately. A partially applied update is discarded.

## Configuration
- PERCEPTRON_BIAS_EN defined: the bias register is included as described.
- PERCEPTRON_BIAS_EN undefined: no bias register, the bias term in sum is 0, and bias_out is tied to 0.

## Structure
- perceptron_pkg:
  - state enum;
  - a sat_add function parameterised by width;
  - an ACC_W helper.
- Sub-module perceptron_dot: the combinational dot product plus bias producing the ACC_W-bit sum. It is instantiated once, driven by the registered sample.

## Test plan
Defaults unless stated; PERCEPTRON_BIAS_EN defined.
- Reset release → w_out={8'd1,8'd1}, bias_out=0, s_ready=0, done=0, busy=0.
- start; sample x=(2,0), t=0, last=1 → y=1, err_cnt=1. Weights become (-1,1) and bias -1. epoch_cnt=1, back in WAIT.
- After restart; x=(0,2), t=1, last=1 → sum=2, y=1, no update. done=1, converged=1, epoch_cnt=1.
- Stream the 10-sample set (0,2)+ (0,1)+ (2,0)- (2,2)- (0,3)+ (1,0)- (2,1)- (1,2)- (1,4)+ (0,7)+, with s_last on the tenth, repeating → converged=1 before MAX_EPOCH. A final replay gives y==t on every sample.
- Per epoch (1,1) t=1 then (1,1) t=0 with last=1 → never converges. done=1, converged=0, epoch_cnt=64.
- LR_SHIFT=5; x=(7,7), t=0 → weights saturate to -128, bias -32.
- start while busy is ignored. rst_n low during EVAL → outputs at reset values within the same cycle.
